exception_arbiter: RTL

Parametrised, registered exception arbiter for the multi-issue MIPS pipeline, sitting at the EX/MEM boundary next to CP0. It collects per-lane exception flags and synchronised interrupt requests, selects the oldest excepting lane by fixed priority, and issues one-cycle CP0 commit strobes. It holds a pipeline flush request for a programmable number of cycles and also handles ERET redirection.

---
 rtl/exception_arbiter.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/exception_arbiter.sv
// Exception arbiter at the EX/MEM boundary: selects the oldest excepting lane,
// issues one-cycle CP0 commit strobes and holds the pipeline flush request.
module exception_arbiter #(
  parameter int          LANES           = 2,
  parameter logic [31:0] EXC_VECTOR      = 32'hbfc00380,
  parameter int          FLUSH_CYCLES    = 1,
  parameter int          INT_SYNC_STAGES = 2,
  localparam int         LANE_W          = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_mem_stall,
  input  logic [LANES-1:0]      lane_valid,
  input  logic [32*LANES-1:0]   lane_pc,
  input  logic [LANES-1:0]      lane_delay_slot,
  input  logic [LANES-1:0]      lane_iaddr_align_err,
  input  logic [LANES-1:0]      lane_invalid_inst,
  input  logic [LANES-1:0]      lane_syscall,
  input  logic [LANES-1:0]      lane_break,
  input  logic [LANES-1:0]      lane_overflow,
  input  logic [LANES-1:0]      lane_daddr_align_err,
  input  logic [LANES-1:0]      lane_mem_wen,
  input  logic [LANES-1:0]      lane_eret,
  input  logic [32*LANES-1:0]   lane_mem_address,
  input  logic [5:0]            hw_int,
  input  logic                  cp0_status_ie,
  input  logic                  cp0_status_exl,
  input  logic [7:0]            cp0_status_im,
  input  logic [1:0]            cp0_cause_ip_sw,
  input  logic [31:0]           cp0_epc_in,
  output logic                  exp_detect,
  output logic [31:0]           exp_pc_address,
  output logic [LANE_W-1:0]     exp_lane,
  output logic                  cp0_exp_en,
  output logic                  cp0_exl_clean,
  output logic                  cp0_exp_bad_vaddr_wen,
  output logic                  cp0_exp_bd,
  output logic [4:0]            cp0_exp_code,
  output logic [31:0]           cp0_exp_epc,
  output logic [31:0]           cp0_exp_bad_vaddr
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_FLUSH} state_t;

  logic [5:0]        r_hw_sync [INT_SYNC_STAGES];
  logic              w_int_pending;

  logic              w_lane_evt   [LANES];
  logic              w_lane_eret  [LANES];
  logic              w_lane_align [LANES];
  logic [4:0]        w_lane_code  [LANES];
  logic [31:0]       w_lane_bad   [LANES];
  logic [31:0]       w_lane_epc   [LANES];

  logic              w_found;
  logic [LANE_W-1:0] w_sel_lane;
  logic              w_sel_eret;
  logic              w_sel_align;
  logic              w_sel_bd;
  logic [4:0]        w_sel_code;
  logic [31:0]       w_sel_bad;
  logic [31:0]       w_sel_epc;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_detect;
  logic [31:0]       r_pc_addr;
  logic [LANE_W-1:0] r_lane;
  logic              r_exp_en;
  logic              r_exl_clean;
  logic              r_bvw;
  logic              r_bd;
  logic [4:0]        r_code;
  logic [31:0]       r_epc;
  logic [31:0]       r_bad;

  // Stage p0: hardware interrupt synchroniser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < INT_SYNC_STAGES; i++) r_hw_sync[i] <= '0;
    end else begin
      r_hw_sync[0] <= hw_int;
      for (int i = 1; i < INT_SYNC_STAGES; i++) r_hw_sync[i] <= r_hw_sync[i-1];
    end
  end

  assign w_int_pending = cp0_status_ie & ~cp0_status_exl &
                         (|(cp0_status_im & {r_hw_sync[INT_SYNC_STAGES-1], cp0_cause_ip_sw}));

  // Per-lane cause decode, highest priority cause tested first
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_lane_evt[i]   = 1'b1;
      w_lane_eret[i]  = 1'b0;
      w_lane_align[i] = 1'b0;
      w_lane_code[i]  = 5'h00;
      w_lane_bad[i]   = 32'h0;
      w_lane_epc[i]   = lane_delay_slot[i] ? (lane_pc[32*i +: 32] - 32'd4) : lane_pc[32*i +: 32];
      if (!lane_valid[i]) begin
        w_lane_evt[i] = 1'b0;
      end else if (i == 0 && w_int_pending) begin
        w_lane_code[i] = 5'h00;
      end else if (lane_iaddr_align_err[i]) begin
        w_lane_code[i]  = 5'h04;
        w_lane_align[i] = 1'b1;
        w_lane_bad[i]   = lane_pc[32*i +: 32];
      end else if (lane_invalid_inst[i]) begin
        w_lane_code[i] = 5'h0a;
      end else if (lane_syscall[i]) begin
        w_lane_code[i] = 5'h08;
      end else if (lane_break[i]) begin
        w_lane_code[i] = 5'h09;
      end else if (lane_overflow[i]) begin
        w_lane_code[i] = 5'h0c;
      end else if (lane_daddr_align_err[i]) begin
        w_lane_code[i]  = lane_mem_wen[i] ? 5'h05 : 5'h04;
        w_lane_align[i] = 1'b1;
        w_lane_bad[i]   = lane_mem_address[32*i +: 32];
      end else if (lane_eret[i]) begin
        w_lane_eret[i] = 1'b1;
      end else begin
        w_lane_evt[i] = 1'b0;
      end
    end
  end

  // Scan youngest to oldest so the oldest excepting lane overrides the rest
  always_comb begin
    w_found     = 1'b0;
    w_sel_lane  = '0;
    w_sel_eret  = 1'b0;
    w_sel_align = 1'b0;
    w_sel_bd    = 1'b0;
    w_sel_code  = 5'h00;
    w_sel_bad   = 32'h0;
    w_sel_epc   = 32'h0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (w_lane_evt[i]) begin
        w_found     = 1'b1;
        w_sel_lane  = LANE_W'(i);
        w_sel_eret  = w_lane_eret[i];
        w_sel_align = w_lane_align[i];
        w_sel_bd    = lane_delay_slot[i];
        w_sel_code  = w_lane_code[i];
        w_sel_bad   = w_lane_bad[i];
        w_sel_epc   = w_lane_epc[i];
      end
    end
  end

  // Stage p1: commit / flush sequencer with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_detect    <= 1'b0;
      r_pc_addr   <= EXC_VECTOR;
      r_lane      <= '0;
      r_exp_en    <= 1'b0;
      r_exl_clean <= 1'b0;
      r_bvw       <= 1'b0;
      r_bd        <= 1'b0;
      r_code      <= 5'h00;
      r_epc       <= 32'h0;
      r_bad       <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!ex_mem_stall && w_found) begin
            r_state     <= S_COMMIT;
            r_detect    <= 1'b1;
            r_exp_en    <= ~w_sel_eret;
            r_exl_clean <= w_sel_eret;
            r_bvw       <= w_sel_align;
            r_pc_addr   <= w_sel_eret ? cp0_epc_in : EXC_VECTOR;
            r_lane      <= w_sel_lane;
            r_bd        <= w_sel_bd;
            r_code      <= w_sel_code;
            r_epc       <= w_sel_epc;
            r_bad       <= w_sel_bad;
          end
        end
        S_COMMIT: begin
          r_exp_en    <= 1'b0;
          r_exl_clean <= 1'b0;
          r_bvw       <= 1'b0;
          if (FLUSH_CYCLES > 1) begin
            r_state <= S_FLUSH;
            r_cnt   <= CNT_W'(FLUSH_CYCLES - 1);
          end else begin
            r_state  <= S_IDLE;
            r_detect <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_state  <= S_IDLE;
            r_detect <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_detect <= 1'b0;
        end
      endcase
    end
  end

  assign exp_detect            = r_detect;
  assign exp_pc_address        = r_pc_addr;
  assign exp_lane              = r_lane;
  assign cp0_exp_en            = r_exp_en;
  assign cp0_exl_clean         = r_exl_clean;
  assign cp0_exp_bad_vaddr_wen = r_bvw;
  assign cp0_exp_bd            = r_bd;
  assign cp0_exp_code          = r_code;
  assign cp0_exp_epc           = r_epc;
  assign cp0_exp_bad_vaddr     = r_bad;

endmodule
